jump_redirect_ctrl: RTL

- Producer side of the jump address calculation path: accepts a resolved JAL/JALR from decode, drives the base/offset/select operands, registers the computed target, and issues a held redirect request to fetch.
- Also returns the link address (pc + 4) for rd writeback.
- Sits between decode/execute and the fetch stage. Stalls the pipeline while a redirect is outstanding.

---
 rtl/jump_redirect_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/jump_redirect_ctrl.sv
// Jump target producer: latches a resolved JAL/JALR, registers base + offset and holds the redirect
// for fetch. Define JUMP_REDIRECT_MISALIGN_EN to trap targets that are not 4-byte aligned.
module jump_redirect_ctrl #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned LINK_OFFSET = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            jump_valid,
   output logic            jump_ready,
   input  logic            j_sel,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_data,
   input  logic            flush,
   output logic            redirect_valid,
   input  logic            redirect_ready,
   output logic [XLEN-1:0] redirect_addr,
   output logic [XLEN-1:0] link_addr,
   output logic            busy,
   output logic            exc_valid,
   output logic [XLEN-1:0] exc_tval
);

   typedef logic [XLEN-1:0] word_t;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StCalc     = 2'd1,
      StRedirect = 2'd2
`ifdef JUMP_REDIRECT_MISALIGN_EN
      ,
      StFault    = 2'd3
`endif
   } state_t;

   state_t state_q;
   word_t  base_q;
   word_t  offset_q;
   logic   jsel_q;
   word_t  link_q;
   word_t  redir_q;
   word_t  sum;
   word_t  target;

   // Carry out of the add is discarded; JALR forces bit 0 low.
   assign sum    = base_q + offset_q;
   assign target = {sum[XLEN-1:1], sum[0] & jsel_q};

`ifdef JUMP_REDIRECT_MISALIGN_EN
   word_t tval_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tval_q <= '0;
      end else if (!flush && state_q == StCalc && target[1]) begin
         tval_q <= target;
      end
   end

   assign exc_valid = (state_q == StFault);
   assign exc_tval  = tval_q;
`else
   assign exc_valid = 1'b0;
   assign exc_tval  = '0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= StIdle;
         base_q   <= '0;
         offset_q <= '0;
         jsel_q   <= 1'b0;
         link_q   <= '0;
         redir_q  <= '0;
      end else if (flush) begin
         state_q <= StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (jump_valid) begin
                  base_q   <= j_sel ? pc : rs1_data;
                  offset_q <= imm;
                  jsel_q   <= j_sel;
                  link_q   <= pc + word_t'(LINK_OFFSET);
                  state_q  <= StCalc;
               end
            end
            StCalc: begin
`ifdef JUMP_REDIRECT_MISALIGN_EN
               if (target[1]) begin
                  state_q <= StFault;
               end else begin
                  redir_q <= target;
                  state_q <= StRedirect;
               end
`else
               redir_q <= target;
               state_q <= StRedirect;
`endif
            end
            StRedirect: begin
               if (redirect_ready) begin
                  state_q <= StIdle;
               end
            end
`ifdef JUMP_REDIRECT_MISALIGN_EN
            StFault: begin
               state_q <= StIdle;
            end
`endif
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign jump_ready     = (state_q == StIdle);
   assign busy           = (state_q != StIdle);
   assign redirect_valid = (state_q == StRedirect);
   assign redirect_addr  = redir_q;
   assign link_addr      = link_q;

endmodule
